window_builder: RTL

Streaming 3x3 window generator that sits directly upstream of the convolution stage. It accepts raster-order 8-bit pixels one per cycle and keeps the two previous image rows in line delays. For every pixel whose 3x3 neighbourhood lies fully inside the image, it presents the complete window plus a one-cycle valid strobe. Its window output and strobe drive the convolver's window input and enable.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/window_builder_line_delay.sv | 24 ++
 rtl/window_builder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 window builder and the downstream convolver:
// default sizes, frame-sequencing state encoding and window tap indexing.
package conv_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_WIDTH = 16;

    localparam int WIN_ROWS   = 3;
    localparam int WIN_COLS   = 3;
    localparam int WIN_TAPS   = WIN_ROWS * WIN_COLS;
    localparam int WIN_CENTER = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

    // Flat tap index of window element (r,c); r=0 oldest row, c=0 oldest column.
    function automatic int win_idx(input int r, input int c);
        return WIN_COLS * r + c;
    endfunction

endpackage

// File: rtl/window_builder_line_delay.sv
// One image-row delay line: column-addressed register array, read returns the
// value stored for this column before the same-cycle write lands.
module line_delay #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MAX_WIDTH)-1:0] addr,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout
);

    logic [DATA_W-1:0] mem [MAX_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/window_builder.sv
// Streaming 3x3 window generator: two line delays plus a 3-column tap shifter,
// emitting a registered window and strobe for every fully interior pixel.
module window_builder
    import conv_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WIDTH = DEF_MAX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic [7:0]            img_width,
    input  logic [7:0]            img_height,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    output logic [9*DATA_W-1:0]   win,
    output logic                  win_valid,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int ADDR_W = $clog2(MAX_WIDTH);

    // Widths are held as "last column index" so the wrap test is a plain compare.
    function automatic logic [ADDR_W-1:0] clamp_w_last(input logic [7:0] w);
        if (w < 8'd3) begin
            return ADDR_W'(2);
        end else if (int'(w) > MAX_WIDTH) begin
            return ADDR_W'(MAX_WIDTH - 1);
        end else begin
            return ADDR_W'(w - 8'd1);
        end
    endfunction

    function automatic logic [7:0] clamp_h_last(input logic [7:0] h);
        if (h < 8'd3) begin
            return 8'd2;
        end else begin
            return h - 8'd1;
        end
    endfunction

    state_t              state_p0, state_cur, state_nxt;
    logic [ADDR_W-1:0]   col_p0, col_cur, col_nxt;
    logic [ADDR_W-1:0]   w_last_p0, w_last_cur;
    logic [7:0]          row_p0, row_cur, row_nxt;
    logic [7:0]          h_last_p0, h_last_cur;
    logic                start_en, accept, last_col, win_hit, frame_end;
    logic [DATA_W-1:0]   l0_rd, l1_rd;
    logic [DATA_W-1:0]   col_new [3];
    logic [9*DATA_W-1:0] taps_p0, taps_nxt, win_p1;
    logic                vld_p1, done_p1;

    // A start in this cycle overrides the frame context seen by the pixel.
    always_comb begin
        start_en   = ena & start;
        state_cur  = start_en ? FILL : state_p0;
        col_cur    = start_en ? '0 : col_p0;
        row_cur    = start_en ? '0 : row_p0;
        w_last_cur = start_en ? clamp_w_last(img_width) : w_last_p0;
        h_last_cur = start_en ? clamp_h_last(img_height) : h_last_p0;
        accept     = ena & pix_valid & (state_cur != IDLE);
        last_col   = (col_cur == w_last_cur);
        win_hit    = accept & (row_cur >= 8'd2) & (col_cur >= ADDR_W'(2));
        frame_end  = accept & (state_cur == STREAM) & last_col & (row_cur == h_last_cur);

        col_nxt   = col_cur;
        row_nxt   = row_cur;
        state_nxt = state_cur;
        if (accept) begin
            col_nxt = last_col ? '0 : col_cur + ADDR_W'(1);
            row_nxt = last_col ? row_cur + 8'd1 : row_cur;
            if (state_cur == FILL && last_col && row_cur == 8'd1) begin
                state_nxt = STREAM;
            end
            if (frame_end) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p0    <= '0;
            row_p0    <= '0;
            w_last_p0 <= ADDR_W'(2);
            h_last_p0 <= 8'd2;
        end else begin
            col_p0    <= col_nxt;
            row_p0    <= row_nxt;
            w_last_p0 <= w_last_cur;
            h_last_p0 <= h_last_cur;
        end
    end

    line_delay #(.DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH)) u_line0 (
        .clk  (clk),
        .we   (accept),
        .addr (col_cur),
        .din  (pix_in),
        .dout (l0_rd)
    );

    line_delay #(.DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH)) u_line1 (
        .clk  (clk),
        .we   (accept),
        .addr (col_cur),
        .din  (l0_rd),
        .dout (l1_rd)
    );

    // Stage p0: tap shifter advances on every accepted pixel.
    always_comb begin
        col_new[0] = l1_rd;
        col_new[1] = l0_rd;
        col_new[2] = pix_in;
        taps_nxt   = taps_p0;
        for (int r = 0; r < 3; r++) begin
            taps_nxt[DATA_W*win_idx(r, 0) +: DATA_W] = taps_p0[DATA_W*win_idx(r, 1) +: DATA_W];
            taps_nxt[DATA_W*win_idx(r, 1) +: DATA_W] = taps_p0[DATA_W*win_idx(r, 2) +: DATA_W];
            taps_nxt[DATA_W*win_idx(r, 2) +: DATA_W] = col_new[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            taps_p0 <= taps_nxt;
        end
    end

    // Stage p1: published window only changes on a complete interior window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_p1  <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= win_hit;
            done_p1 <= frame_end;
            if (win_hit) begin
                win_p1 <= taps_nxt;
            end
        end
    end

    assign win        = win_p1;
    assign win_valid  = vld_p1;
    assign frame_done = done_p1;
    assign busy       = (state_p0 != IDLE);

endmodule
